// File: rtl/blockade_input_cond.sv
// Input conditioner: sync + debounce raw controls, frame-aligned coin pulse, pack active-low in1/in2 (optional SOCD cleaning: BLOCKADE_SOCD_EN).
// Latency: raw edge to in2 is DEBOUNCE_CYCLES+3 clk_sys cycles; coin pulse starts one cycle after the first vblank rise after acceptance.
// Backpressure: none; outputs refresh every cycle, presses arriving while the coin FSM is busy are dropped.
module blockade_input_cond #(
    parameter logic [15:0] DEBOUNCE_CYCLES   = 16'd1024,
    parameter int          COIN_PULSE_FRAMES = 3
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [8:0] inputs,
    input  logic       vblank,
    input  logic [2:0] dip_lives,
    output logic [7:0] in1,
    output logic [7:0] in2,
    output logic [7:0] coin_count,
    output logic       coin_busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] ACTIVE  = 2'd2;
    localparam logic [1:0] HOLDOFF = 2'd3;
    localparam logic [3:0] PULSE_FRAMES = 4'(COIN_PULSE_FRAMES);

    logic [8:0]  sync1;
    logic [8:0]  sync2;
    logic [8:0]  deb;
    logic [15:0] deb_cnt [9];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < 9; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= inputs;
            sync2 <= sync1;
            for (int i = 0; i < 9; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 16'd1;
                end
            end
        end
    end

    // clean[] keeps the raw input bit numbering; dir[] is the in2 packing order
    logic [7:0] clean;
    logic [7:0] dir;
`ifdef BLOCKADE_SOCD_EN
    logic p1_lr, p1_ud, p2_lr, p2_ud;
    always_comb begin
        p1_lr = deb[0] & deb[1];
        p1_ud = deb[2] & deb[3];
        p2_lr = deb[4] & deb[5];
        p2_ud = deb[6] & deb[7];
        clean = deb[7:0] & ~{p2_ud, p2_ud, p2_lr, p2_lr, p1_ud, p1_ud, p1_lr, p1_lr};
    end
`else
    assign clean = deb[7:0];
`endif
    assign dir = {clean[5], clean[6], clean[4], clean[7], clean[1], clean[2], clean[0], clean[3]};

    logic       vblank_q;
    logic       vb_rise;
    logic       dc_q;
    logic       coin_rise;
    logic [1:0] state;
    logic [3:0] frames;
    logic       coin_q;
    logic [7:0] in2_q;
    logic [7:0] count_q;

    assign vb_rise   = vblank & ~vblank_q;
    assign coin_rise = deb[8] & ~dc_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vblank_q <= 1'b0;
            dc_q     <= 1'b0;
            state    <= IDLE;
            frames   <= '0;
            count_q  <= '0;
            coin_q   <= 1'b0;
            in2_q    <= 8'hFF;
        end else begin
            vblank_q <= vblank;
            dc_q     <= deb[8];
            coin_q   <= (state == ACTIVE);
            in2_q    <= ~dir;
            case (state)
                IDLE: if (coin_rise) begin
                    state   <= ARMED;
                    count_q <= count_q + 8'd1;
                end
                ARMED: if (vb_rise) begin
                    state  <= ACTIVE;
                    frames <= PULSE_FRAMES;
                end
                // leaving on the 1->0 decrement keeps the pulse exactly PULSE_FRAMES frames long
                ACTIVE: if (vb_rise) begin
                    frames <= frames - 4'd1;
                    if (frames == 4'd1) state <= HOLDOFF;
                end
                default: if (!deb[8]) state <= IDLE;
            endcase
        end
    end

    assign in1        = {~coin_q, ~dip_lives, 4'b1011};
    assign in2        = in2_q;
    assign coin_count = count_q;
    assign coin_busy  = (state != IDLE);

endmodule

// File: tb/tb_blockade_input_cond.sv
// Directed bench for blockade_input_cond with DEBOUNCE_CYCLES=4, COIN_PULSE_FRAMES=3.
module tb_blockade_input_cond;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic [8:0] inputs;
    logic       vblank;
    logic [2:0] dip_lives;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [7:0] coin_count;
    logic       coin_busy;

    int checks   = 0;
    int failures = 0;

    blockade_input_cond #(
        .DEBOUNCE_CYCLES  (16'd4),
        .COIN_PULSE_FRAMES(3)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .inputs    (inputs),
        .vblank    (vblank),
        .dip_lives (dip_lives),
        .in1       (in1),
        .in2       (in2),
        .coin_count(coin_count),
        .coin_busy (coin_busy)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [8:0] inp;
        logic [2:0] dip;
        logic [7:0] in2_exp;
        logic [7:0] in1_exp;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic vb_pulse();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        tick();
    endtask

    // in1 with dip 100: pulse inactive / active
    localparam logic [7:0] IN1_IDLE  = 8'hBB;
    localparam logic [7:0] IN1_PULSE = 8'h3B;

    vec_t       tbl [12];
    logic [7:0] worst;
    logic [7:0] socd_lr;
    logic [7:0] socd_ud;
    logic [7:0] socd_all;

    initial begin
`ifdef BLOCKADE_SOCD_EN
        socd_lr  = 8'hFF;
        socd_ud  = 8'hFF;
        socd_all = 8'hFF;
`else
        socd_lr  = 8'hF5;
        socd_ud  = 8'hAF;
        socd_all = 8'h00;
`endif
        tbl[0]  = '{9'h000, 3'b100, 8'hFF, 8'hBB};
        tbl[1]  = '{9'h001, 3'b100, 8'hFD, 8'hBB};
        tbl[2]  = '{9'h002, 3'b000, 8'hF7, 8'hFB};
        tbl[3]  = '{9'h004, 3'b110, 8'hFB, 8'h9B};
        tbl[4]  = '{9'h008, 3'b011, 8'hFE, 8'hCB};
        tbl[5]  = '{9'h010, 3'b100, 8'hDF, 8'hBB};
        tbl[6]  = '{9'h020, 3'b100, 8'h7F, 8'hBB};
        tbl[7]  = '{9'h040, 3'b100, 8'hBF, 8'hBB};
        tbl[8]  = '{9'h080, 3'b100, 8'hEF, 8'hBB};
        tbl[9]  = '{9'h0A5, 3'b100, 8'h69, 8'hBB};
        tbl[10] = '{9'h003, 3'b100, socd_lr, 8'hBB};
        tbl[11] = '{9'h0C0, 3'b100, socd_ud, 8'hBB};

        reset_n   = 1'b0;
        inputs    = '0;
        vblank    = 1'b0;
        dip_lives = 3'b100;
        #12;
        check("reset_in2", in2, 8'hFF);
        check("reset_in1", in1, IN1_IDLE);
        check("reset_count", coin_count, 8'd0);
        check("reset_busy", {7'd0, coin_busy}, 8'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        tick(2);

        // latency: raw edge just after edge 0 appears on in2 at edge 7
        inputs = 9'h001;
        tick(6);
        check("latency_edge6", in2, 8'hFF);
        tick();
        check("latency_edge7", in2, 8'hFD);

        inputs = 9'h009;
        tick(3);
        inputs = 9'h001;
        worst = 8'hFD;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (in2 !== 8'hFD) worst = in2;
        end
        check("glitch_reject", worst, 8'hFD);

        for (int i = 0; i < 12; i++) begin
            inputs    = tbl[i].inp;
            dip_lives = tbl[i].dip;
            tick(8);
            check($sformatf("vec%0d_in2", i), in2, tbl[i].in2_exp);
            check($sformatf("vec%0d_in1", i), in1, tbl[i].in1_exp);
        end
        inputs = 9'h0FF;
        tick(8);
        check("all_dirs_in2", in2, socd_all);
        inputs    = '0;
        dip_lives = 3'b100;
        tick(8);

        // coin held 20 cycles, then 50-cycle frames
        inputs[8] = 1'b1;
        tick(20);
        check("coin_armed_count", coin_count, 8'd1);
        check("coin_armed_busy", {7'd0, coin_busy}, 8'd1);
        check("coin_armed_in1", in1, IN1_IDLE);
        inputs[8] = 1'b0;
        tick(10);
        vb_pulse();
        check("coin_frame1", in1, IN1_PULSE);
        for (int f = 2; f <= 4; f++) begin
            tick(48);
            check($sformatf("coin_pre_vb%0d", f), in1, IN1_PULSE);
            vb_pulse();
            check($sformatf("coin_post_vb%0d", f), in1, (f < 4) ? IN1_PULSE : IN1_IDLE);
        end
        check("coin_done_busy", {7'd0, coin_busy}, 8'd0);
        check("coin_done_count", coin_count, 8'd1);

        // second press while ACTIVE is ignored; later press counts
        do_reset();
        inputs[8] = 1'b1;
        tick(8);
        inputs[8] = 1'b0;
        tick(8);
        vb_pulse();
        check("p2_active", in1, IN1_PULSE);
        inputs[8] = 1'b1;
        tick(10);
        inputs[8] = 1'b0;
        tick(10);
        check("p2_ignored_count", coin_count, 8'd1);
        vb_pulse();
        vb_pulse();
        check("p2_vb3", in1, IN1_PULSE);
        vb_pulse();
        check("p2_end", in1, IN1_IDLE);
        check("p2_end_busy", {7'd0, coin_busy}, 8'd0);
        check("p2_end_count", coin_count, 8'd1);
        inputs[8] = 1'b1;
        tick(8);
        check("p3_count", coin_count, 8'd2);
        check("p3_busy", {7'd0, coin_busy}, 8'd1);
        inputs[8] = 1'b0;
        tick(8);
        vb_pulse();
        check("p3_vb1", in1, IN1_PULSE);
        vb_pulse();
        vb_pulse();
        check("p3_vb3", in1, IN1_PULSE);
        vb_pulse();
        check("p3_vb4", in1, IN1_IDLE);

        // asynchronous reset while ACTIVE
        inputs[8] = 1'b1;
        tick(8);
        inputs[8] = 1'b0;
        tick(8);
        vb_pulse();
        check("arst_pre", in1, IN1_PULSE);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_in1", in1, IN1_IDLE);
        check("arst_busy", {7'd0, coin_busy}, 8'd0);
        check("arst_count", coin_count, 8'd0);

        // coin held through reset release counts as a fresh press
        inputs[8] = 1'b1;
        #1;
        reset_n = 1'b1;
        tick(6);
        check("held_edge6", coin_count, 8'd0);
        tick();
        check("held_edge7", coin_count, 8'd1);
        inputs[8] = 1'b0;
        tick(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
